// File: rtl/pipeline_pkg.sv
// Shared writeback-stage types: load funct3 encodings, register index width, WB entry.
package pipeline_pkg;
   localparam int REG_IDX_W = 5;
   localparam int XLEN      = 64;

   localparam logic [2:0] LD_B  = 3'b000;
   localparam logic [2:0] LD_H  = 3'b001;
   localparam logic [2:0] LD_W  = 3'b010;
   localparam logic [2:0] LD_D  = 3'b011;
   localparam logic [2:0] LD_BU = 3'b100;
   localparam logic [2:0] LD_HU = 3'b101;
   localparam logic [2:0] LD_WU = 3'b110;

   typedef struct packed {
      logic [REG_IDX_W-1:0] dst;
      logic [XLEN-1:0]      val;
      logic                 wr_en;
      logic                 ld_err;
   } wb_entry_t;
endpackage

// File: rtl/wb_load_extend.sv
// Combinational RV64 load extension; unknown funct3 passes raw data and flags err.
module wb_load_extend
   import pipeline_pkg::*;
(
   input  logic            is_load,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] raw,
   output logic [XLEN-1:0] ext,
   output logic            err
);
   always_comb begin
      ext = raw;
      err = 1'b0;
      if (is_load) begin
         case (funct3)
            LD_B:    ext = {{56{raw[7]}},  raw[7:0]};
            LD_H:    ext = {{48{raw[15]}}, raw[15:0]};
            LD_W:    ext = {{32{raw[31]}}, raw[31:0]};
            LD_D:    ext = raw;
            LD_BU:   ext = {56'd0, raw[7:0]};
            LD_HU:   ext = {48'd0, raw[15:0]};
            LD_WU:   ext = {32'd0, raw[31:0]};
            default: err = 1'b1;
         endcase
      end
   end
endmodule

// File: rtl/pipeline_writeback.sv
// Writeback stage: WB register, 32-entry regfile with two read ports, retire counter.
// Optional same-cycle read bypass of the committing write: define REGFILE_BYPASS_EN.
module pipeline_writeback
   import pipeline_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_REGS   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [REG_IDX_W-1:0]  mem_dst_reg,
   input  logic [DATA_WIDTH-1:0] mem_dst_val,
   input  logic                  mem_wr_en,
   input  logic                  mem_is_load,
   input  logic [2:0]            mem_ld_funct3,
   input  logic                  hold,
   input  logic [REG_IDX_W-1:0]  rs1_idx,
   output logic [DATA_WIDTH-1:0] rs1_val,
   input  logic [REG_IDX_W-1:0]  rs2_idx,
   output logic [DATA_WIDTH-1:0] rs2_val,
   output logic                  ld_err,
   output logic [63:0]           retire_count
);
   wb_entry_t                            wb_q;
   logic                                 wb_valid;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs;
   logic [DATA_WIDTH-1:0]                ext_val;
   logic                                 ext_err;
   logic                                 capture;
   logic                                 commit;
   logic                                 commit_wr;

   wb_load_extend u_ext (
      .is_load (mem_is_load),
      .funct3  (mem_ld_funct3),
      .raw     (mem_dst_val),
      .ext     (ext_val),
      .err     (ext_err)
   );

   assign mem_ready = !wb_valid || !hold;
   assign capture   = mem_valid && mem_ready;
   // An entry sitting in WB during a reset cycle is dropped, not committed.
   assign commit    = wb_valid && !hold && !reset;
   assign commit_wr = commit && wb_q.wr_en && (wb_q.dst != '0);
   assign ld_err    = commit && wb_q.ld_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_valid     <= 1'b0;
         wb_q         <= '0;
         regs         <= '0;
         retire_count <= '0;
      end else begin
         if (capture) begin
            wb_valid    <= 1'b1;
            wb_q.dst    <= mem_dst_reg;
            wb_q.val    <= ext_val;
            wb_q.wr_en  <= mem_wr_en;
            wb_q.ld_err <= ext_err;
         end else if (commit) begin
            wb_valid <= 1'b0;
         end
         if (commit) retire_count <= retire_count + 64'd1;
         if (commit_wr) regs[wb_q.dst] <= wb_q.val;
      end
   end

   always_comb begin
      rs1_val = regs[rs1_idx];
      rs2_val = regs[rs2_idx];
`ifdef REGFILE_BYPASS_EN
      if (commit_wr && (wb_q.dst == rs1_idx)) rs1_val = wb_q.val;
      if (commit_wr && (wb_q.dst == rs2_idx)) rs2_val = wb_q.val;
`endif
      if (rs1_idx == '0) rs1_val = '0;
      if (rs2_idx == '0) rs2_val = '0;
   end
endmodule
